// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: sender state encoding, default timing parameters,
// host command bytes and the frame parity helper.
package ps2_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE     = 3'd0;
    localparam state_t ST_INHIBIT  = 3'd1;
    localparam state_t ST_START    = 3'd2;
    localparam state_t ST_SEND     = 3'd3;
    localparam state_t ST_WAITACK  = 3'd4;
    localparam state_t ST_WAITIDLE = 3'd5;

    localparam int unsigned DEF_INHIBIT_CYCLES = 2800;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 420000;
    localparam int unsigned DEF_FILTER_LEN     = 8;

    localparam logic [7:0] CMD_SET_LEDS  = 8'hED;
    localparam logic [7:0] CMD_RESET     = 8'hFF;
    localparam logic [7:0] CMD_TYPEMATIC = 8'hF3;

    // Parity bit that makes the 9-bit {parity, data} word have an odd number of ones.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer plus run-length glitch filter for one open-collector
// PS/2 line; flags a falling edge of the filtered level.
module ps2_line_filter
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic fall
);

    localparam int unsigned CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic          sync_q1;
    logic          sync_q2;
    logic [CW-1:0] run_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
            level   <= 1'b1;
            run_cnt <= '0;
            fall    <= 1'b0;
        end else begin
            sync_q1 <= pin;
            sync_q2 <= sync_q1;
            fall    <= 1'b0;
            // Any sample matching the current level restarts the run.
            if (sync_q2 == level) begin
                run_cnt <= '0;
            end else if (run_cnt == CW'(FILTER_LEN - 1)) begin
                level   <= sync_q2;
                run_cnt <= '0;
                fall    <= level;
            end else begin
                run_cnt <= run_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_host_sender.sv
// Host-to-device PS/2 command transmitter: inhibits the bus, issues the start
// bit, clocks out data/parity/stop on device clock edges and collects the ACK.
module ps2_host_sender
    import ps2_pkg::*;
#(
    parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int unsigned FILTER_LEN     = DEF_FILTER_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2clk_in,
    input  logic       ps2data_in,
    output logic       ps2clk_oe,
    output logic       ps2data_oe,
    input  logic [7:0] data,
    input  logic       dataload,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       timeout
);

    localparam int unsigned CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [8:0]       shreg;
    logic [3:0]       bit_idx;
    logic             clk_f;
    logic             clk_fall;
    logic             data_f;
    logic             data_fall_unused;
    logic             in_frame;
    logic             expired;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2clk_in),
        .level (clk_f),
        .fall  (clk_fall)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
        .clk   (clk),
        .rst   (rst),
        .pin   (ps2data_in),
        .level (data_f),
        .fall  (data_fall_unused)
    );

    always_comb begin
        in_frame = (state == ST_SEND) || (state == ST_WAITACK) || (state == ST_WAITIDLE);
        expired  = in_frame && !clk_fall && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            shreg      <= '0;
            bit_idx    <= '0;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            ack_ok     <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (in_frame) begin
                cnt <= clk_fall ? '0 : cnt + CNT_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (dataload && !busy) begin
                        shreg     <= {odd_parity(data), data};
                        ack_ok    <= 1'b0;
                        timeout   <= 1'b0;
                        ps2clk_oe <= 1'b1;
                        cnt       <= '0;
                        busy      <= 1'b1;
                        state     <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
                        ps2data_oe <= 1'b1;
                        state      <= ST_START;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_START: begin
                    ps2clk_oe <= 1'b0;
                    bit_idx   <= '0;
                    cnt       <= '0;
                    state     <= ST_SEND;
                end
                ST_SEND: begin
                    if (clk_fall) begin
                        if (bit_idx == 4'd9) begin
                            ps2data_oe <= 1'b0;
                            state      <= ST_WAITACK;
                        end else begin
                            ps2data_oe <= ~shreg[0];
                            shreg      <= shreg >> 1;
                            bit_idx    <= bit_idx + 4'd1;
                        end
                    end
                end
                ST_WAITACK: begin
                    if (clk_fall) begin
                        ack_ok <= ~data_f;
                        state  <= ST_WAITIDLE;
                    end
                end
                ST_WAITIDLE: begin
                    if (clk_f && data_f) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Abort overrides whatever the state branch scheduled this cycle.
            if (expired) begin
                ps2clk_oe  <= 1'b0;
                ps2data_oe <= 1'b0;
                timeout    <= 1'b1;
                ack_ok     <= 1'b0;
                done       <= 1'b1;
                busy       <= 1'b0;
                state      <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_ps2_host_sender.sv
// Bench for ps2_host_sender: open-collector device model with a bit/ACK
// scoreboard, timeout, glitch, busy-load and mid-frame reset scenarios.
module tb_ps2_host_sender;
    import ps2_pkg::*;

    localparam int unsigned INH  = 40;
    localparam int unsigned TMO  = 2000;
    localparam int unsigned FLT  = 4;
    localparam int unsigned HALF = 30;

    logic       clk = 1'b0;
    logic       rst;
    logic       ps2clk_in;
    logic       ps2data_in;
    logic       ps2clk_oe;
    logic       ps2data_oe;
    logic [7:0] data;
    logic       dataload;
    logic       busy;
    logic       done;
    logic       ack_ok;
    logic       timeout;

    logic bfm_clk_low  = 1'b0;
    logic bfm_data_low = 1'b0;
    logic glitch       = 1'b0;

    assign ps2clk_in  = ~(ps2clk_oe | bfm_clk_low | glitch);
    assign ps2data_in = ~(ps2data_oe | bfm_data_low);

    int checks   = 0;
    int failures = 0;

    logic       exp_bits[$];
    logic [1:0] exp_end[$];

    int done_cnt    = 0;
    int done_base   = 0;
    int clk_oe_run  = 0;
    int clk_oe_len  = 0;
    int data_oe_run = 0;
    int data_lead   = 0;

    ps2_host_sender #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TMO),
        .FILTER_LEN     (FLT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2clk_in  (ps2clk_in),
        .ps2data_in (ps2data_in),
        .ps2clk_oe  (ps2clk_oe),
        .ps2data_oe (ps2data_oe),
        .data       (data),
        .dataload   (dataload),
        .busy       (busy),
        .done       (done),
        .ack_ok     (ack_ok),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (ps2clk_oe) begin
            clk_oe_run++;
        end else if (clk_oe_run != 0) begin
            clk_oe_len = clk_oe_run;
            data_lead  = data_oe_run;
            clk_oe_run = 0;
        end
        if (ps2data_oe && ps2clk_oe) data_oe_run++;
        else if (!ps2clk_oe) data_oe_run = 0;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_byte(input logic [7:0] b, input logic exp_ack, input logic exp_tmo);
        @(negedge clk);
        #1;
        done_base = done_cnt;
        data      = b;
        dataload  = 1'b1;
        for (int i = 0; i < 8; i++) exp_bits.push_back(b[i]);
        exp_bits.push_back(~(^b));
        exp_bits.push_back(1'b1);
        exp_end.push_back({exp_ack, exp_tmo});
        @(negedge clk);
        dataload = 1'b0;
        check_val("busy_rise", 32'(busy), 32'(1));
    endtask

    // Device model: clocks 11 bits, samples before each rising edge.
    task automatic bfm_frame(input logic do_ack, input int stop_after, input int glitch_after);
        int   n;
        logic expv;
        n = 0;
        while (!(ps2clk_in && !ps2data_in) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            check_val("bfm_start_wait", 32'(0), 32'(1));
            return;
        end
        repeat (HALF) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            bfm_clk_low = 1'b1;
            repeat (HALF) @(negedge clk);
            if (e == stop_after) return;
            if (e <= 10) begin
                if (exp_bits.size() == 0) begin
                    check_val($sformatf("bit%0d_queue", e), 32'(0), 32'(1));
                end else begin
                    expv = exp_bits.pop_front();
                    check_val($sformatf("bit%0d", e), 32'(ps2data_in), 32'(expv));
                end
            end
            bfm_clk_low = 1'b0;
            if (e == 10 && do_ack) bfm_data_low = 1'b1;
            if (e == 11) begin
                bfm_data_low = 1'b0;
                return;
            end
            if (e == glitch_after) begin
                repeat (HALF / 2) @(negedge clk);
                glitch = 1'b1;
                repeat (FLT - 1) @(negedge clk);
                glitch = 1'b0;
                repeat (HALF - HALF / 2 - (FLT - 1)) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        int         n;
        logic [1:0] e;
        n = 0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            check_val({tag, "_done_wait"}, 32'(0), 32'(1));
            return;
        end
        e = (exp_end.size() != 0) ? exp_end.pop_front() : 2'bxx;
        check_val({tag, "_ack_ok"}, 32'(ack_ok), 32'(e[1]));
        check_val({tag, "_timeout"}, 32'(timeout), 32'(e[0]));
        check_val({tag, "_busy_low"}, 32'(busy), 32'(0));
        check_val({tag, "_oes"}, 32'({ps2clk_oe, ps2data_oe}), 32'(0));
        @(negedge clk);
        #1;
        check_val({tag, "_done_once"}, 32'(done_cnt - done_base), 32'(1));
        check_val({tag, "_inhibit_len"}, 32'(clk_oe_len), 32'(INH + 1));
        check_val({tag, "_start_lead"}, 32'(data_lead), 32'(1));
    endtask

    initial begin
        int n;
        rst      = 1'b1;
        dataload = 1'b0;
        data     = '0;
        repeat (3) @(negedge clk);
        check_val("rst_clk_oe", 32'(ps2clk_oe), 32'(0));
        check_val("rst_data_oe", 32'(ps2data_oe), 32'(0));
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        check_val("rst_ack_ok", 32'(ack_ok), 32'(0));
        check_val("rst_timeout", 32'(timeout), 32'(0));
        rst = 1'b0;
        repeat (20) @(negedge clk);

        // Set LEDs with ACK from the device.
        load_byte(CMD_SET_LEDS, 1'b1, 1'b0);
        bfm_frame(1'b1, 0, 0);
        wait_done("ed", 200);
        repeat (20) @(negedge clk);

        // No ACK: data left high on the 11th clock.
        load_byte(8'h01, 1'b0, 1'b0);
        bfm_frame(1'b0, 0, 0);
        wait_done("01", 200);
        repeat (20) @(negedge clk);

        // No device: clock never toggles after release.
        load_byte(8'hAA, 1'b0, 1'b1);
        n = 0;
        while (ps2clk_oe && n < int'(INH) + 10) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (done !== 1'b1 && n < int'(TMO) + 100) begin
            @(negedge clk);
            n++;
        end
        check_val("tmo_latency", 32'(n), 32'(TMO));
        wait_done("tmo", 10);
        exp_bits.delete();
        repeat (20) @(negedge clk);

        // Sub-filter clock glitch in the high phase after edge 3.
        load_byte(CMD_TYPEMATIC, 1'b1, 1'b0);
        bfm_frame(1'b1, 0, 3);
        wait_done("glitch", 200);
        repeat (20) @(negedge clk);

        // Load attempt while busy must be ignored.
        load_byte(8'hA3, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        data     = 8'h55;
        dataload = 1'b1;
        @(negedge clk);
        dataload = 1'b0;
        bfm_frame(1'b1, 0, 0);
        wait_done("busyload", 200);
        repeat (60) @(negedge clk);
        check_val("busyload_idle", 32'(busy), 32'(0));

        // Reset after the 5th device clock edge (D4 = 0 drives data low).
        load_byte(8'h2C, 1'b1, 1'b0);
        bfm_frame(1'b1, 5, 0);
        check_val("pre_rst_data_oe", 32'(ps2data_oe), 32'(1));
        check_val("pre_rst_busy", 32'(busy), 32'(1));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("midrst_oes", 32'({ps2clk_oe, ps2data_oe}), 32'(0));
        check_val("midrst_busy", 32'(busy), 32'(0));
        bfm_clk_low = 1'b0;
        exp_bits.delete();
        exp_end.delete();
        repeat (40) @(negedge clk);

        load_byte(CMD_RESET, 1'b1, 1'b0);
        bfm_frame(1'b1, 0, 0);
        wait_done("ff", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
